mcm_frame_addr: RTL and testbench
=================================

// Module: mcm_frame_addr
// PURPOSE
//  Parametrised write-address generator for MCM reply frames. Detects iVal strobes (async domain),
//  counts bytes, emits buffer write address and write strobe, flags frame complete. Adds ping-pong
//  bank select, runtime overflow detection and inter-byte timeout. Sits between MCM byte receiver and frame RAM.
// PARAMETERS
//  ADDR_W      8     address width per bank; FRAME_LEN <= 2**ADDR_W required (elaboration check)
//  FRAME_LEN   144   bytes per complete frame
//  SYNC_STAGES 2     iVal synchroniser depth, >=2; edge detect uses one extra flop
//  TIMEOUT     4095  max clk cycles between detected edges while receiving; 0 disables timeout
//  CNT_W       $clog2(FRAME_LEN+1)  byte counter width (localparam)
// PORTS
//  clk       in   1       system clock, all logic on posedge
//  reset     in   1       asynchronous, active-low reset
//  iRQ       in   1       request pulse/level: synchronous restart of frame reception
//  iVal      in   1       byte-valid strobe from MCM, asynchronous, min high/low 2 clk
//  oAddr     out  ADDR_W  write address within current bank
//  oBank     out  1       bank being written; ~oBank = last completed bank for reader
//  oWe       out  1       one-cycle write strobe, data written at oAddr
//  oCount    out  CNT_W   bytes counted in current frame
//  oDone     out  1       frame complete (FRAME_LEN bytes written)
//  oOvf      out  1       sticky: edge received after frame complete
//  oTimeout  out  1       sticky: inter-byte gap exceeded TIMEOUT
// BEHAVIOUR
//  Reset (reset=0, async): all outputs 0, sync chain 0, timer 0, state IDLE.
//  Sync: chain s[0..SYNC_STAGES], s[0]<=iVal; rise = s[SS-1]&~s[SS], fall = ~s[SS-1]&s[SS].
//  Latency: iVal 1 first sampled at edge k -> oCount updates at edge k+SYNC_STAGES.
//  States: IDLE, RECV, DONE, ERR (2-bit encoded).
//   IDLE: edges ignored; iRQ -> RECV.
//   RECV: rise -> oCount+1. fall -> oWe=1 for one cycle with current oAddr, oAddr+1 next cycle;
//         if oCount==FRAME_LEN on that fall -> oDone=1, state DONE (oAddr wraps to 0 if FRAME_LEN==2**ADDR_W).
//         Timer counts clocks, cleared on every rise/fall; timer==TIMEOUT-1 -> oTimeout=1, ERR.
//   DONE: rise -> oOvf=1; no count, no oWe, oAddr held.
//   ERR : edges ignored, outputs held until iRQ.
//  iRQ (any state, level sampled per clk): next cycle oAddr=0, oCount=0, oDone=0, oOvf=0, oTimeout=0,
//   timer=0, state RECV; oBank toggles only if state was DONE (completed frame preserved for reader).
//   Held iRQ keeps block cleared; reception starts first cycle after iRQ falls.
//  iRQ has priority over simultaneous rise/fall (edge dropped, no oWe).
//  Fall without preceding rise in frame (iVal high at iRQ): oWe still issued, oCount unchanged.
//  oWe never asserted outside RECV; at most one oWe per fall.
//  Reset mid-frame: immediate clear, oBank=0, partial frame discarded.
// TESTING
//  1 Reset, iRQ 1 clk, 144 iVal pulses (3hi/3lo) -> oWe at addr 0..143, oDone=1 after 144th fall, oBank=0.
//  2 After test 1, iRQ -> oBank=1, oAddr=0, oDone=0; second frame writes bank 1, ~oBank=0 reader.
//  3 145th pulse after done -> oOvf=1, no oWe, oAddr=144, oCount=144 held until next iRQ.
//  4 TIMEOUT=16, stop after 10 bytes -> oTimeout=1 exactly 16 clk after last edge, state ERR, edges ignored.
//  5 iRQ coincident with detected fall at byte 50 -> no oWe, oAddr=0, oCount=0; assert reset mid-frame -> all 0.
//  6 ADDR_W=4, FRAME_LEN=16 -> oAddr wraps 15->0 on last fall, oDone=1; iVal glitch <2 clk not required counted.

Source files
------------

// File: rtl/mcm_frame_addr.sv
// mcm_frame_addr: frame-RAM write-address generator for MCM reply frames.
// Synchronises the async byte strobe, counts bytes, ping-pongs banks and flags overflow/timeout.
module mcm_frame_addr #(
  parameter int  ADDR_W      = 8,
  parameter int  FRAME_LEN   = 144,
  parameter int  SYNC_STAGES = 2,
  parameter int  TIMEOUT     = 4095,
  localparam int CNT_W       = $clog2(FRAME_LEN + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              iRQ,
  input  logic              iVal,
  output logic [ADDR_W-1:0] oAddr,
  output logic              oBank,
  output logic              oWe,
  output logic [CNT_W-1:0]  oCount,
  output logic              oDone,
  output logic              oOvf,
  output logic              oTimeout
);

  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_LEN);

  if (FRAME_LEN > (2 ** ADDR_W)) begin : g_len_chk
    $error("mcm_frame_addr: FRAME_LEN does not fit in one bank of 2**ADDR_W");
  end
  if (SYNC_STAGES < 2) begin : g_sync_chk
    $error("mcm_frame_addr: SYNC_STAGES must be at least 2");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RECV = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t              r_state;
  logic [SYNC_STAGES:0] r_sync;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_bank;
  logic                r_we;
  logic                r_last;
  logic [CNT_W-1:0]    r_count;
  logic                r_done;
  logic                r_ovf;
  logic                r_tmo;
  logic [TMR_W-1:0]    r_timer;
  logic                w_rise;
  logic                w_fall;

  // The top flop of the chain is the edge-detect history bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-1:0], iVal};
    end
  end

  assign w_rise = r_sync[SYNC_STAGES-1] & ~r_sync[SYNC_STAGES];
  assign w_fall = ~r_sync[SYNC_STAGES-1] & r_sync[SYNC_STAGES];

  // The write strobe is shown with the current address; the address steps and the
  // frame-complete decision is applied one cycle later, so oWe only ever appears in RECV.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_bank  <= 1'b0;
      r_we    <= 1'b0;
      r_last  <= 1'b0;
      r_count <= '0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
      r_tmo   <= 1'b0;
      r_timer <= '0;
    end else if (iRQ) begin
      if (r_state == S_DONE) begin
        r_bank <= ~r_bank;
      end
      r_state <= S_RECV;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_last  <= 1'b0;
      r_count <= '0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
      r_tmo   <= 1'b0;
      r_timer <= '0;
    end else begin
      r_we   <= 1'b0;
      r_last <= 1'b0;
      if (r_we) begin
        r_addr <= r_addr + ADDR_W'(1);
        if (r_last) begin
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
      end
      case (r_state)
        S_RECV: begin
          if (w_rise || w_fall) begin
            r_timer <= '0;
          end else if ((TIMEOUT != 0) && (r_timer == TMR_LAST) && !r_last) begin
            r_tmo   <= 1'b1;
            r_state <= S_ERR;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
          if (w_rise && (r_count != CNT_FULL)) begin
            r_count <= r_count + CNT_W'(1);
          end
          if (w_fall) begin
            r_we   <= 1'b1;
            r_last <= (r_count == CNT_FULL);
          end
        end
        S_DONE: begin
          r_timer <= '0;
          if (w_rise) begin
            r_ovf <= 1'b1;
          end
        end
        default: begin
          r_timer <= '0;
        end
      endcase
    end
  end

  assign oAddr    = r_addr;
  assign oBank    = r_bank;
  assign oWe      = r_we;
  assign oCount   = r_count;
  assign oDone    = r_done;
  assign oOvf     = r_ovf;
  assign oTimeout = r_tmo;

endmodule

// File: tb/tb_mcm_frame_addr.sv
// tb_mcm_frame_addr: self-checking bench for mcm_frame_addr with a short-frame instance (table,
// latency, timeout) and a full-size instance (hand sequences plus randomized frames vs. a frame model).
`timescale 1ns/1ps
module tb_mcm_frame_addr;

  localparam int A_LEN = 144;
  localparam int B_TMO = 16;

  typedef struct {
    int nPulses;
    int hi;
    int lo;
    int expCount;
    int expAddr;
    int expDone;
    int expOvf;
    int expBank;
    int expWrites;
  } vecT;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic rqA = 1'b0, valA = 1'b0, rqB = 1'b0, valB = 1'b0;

  logic [7:0] addrA;
  logic [7:0] countA;
  logic       bankA, weA, doneA, ovfA, tmoA;
  logic [3:0] addrB;
  logic [4:0] countB;
  logic       bankB, weB, doneB, ovfB, tmoB;

  int nCompared = 0;
  int nMismatch = 0;
  int cyc = 0;
  int qA[$];
  int qB[$];
  int rdA = 0;
  int rdB = 0;
  int lastWeCycB = -1;
  int tmoRiseCycB = -1;
  logic prevTmoB = 1'b0;
  int bankM = 0;
  int prevDoneM = 0;

  always #5 clk = ~clk;

  mcm_frame_addr #(.ADDR_W(8), .FRAME_LEN(A_LEN), .SYNC_STAGES(2), .TIMEOUT(4095)) dutA (
    .clk(clk), .reset(reset), .iRQ(rqA), .iVal(valA), .oAddr(addrA), .oBank(bankA),
    .oWe(weA), .oCount(countA), .oDone(doneA), .oOvf(ovfA), .oTimeout(tmoA));

  mcm_frame_addr #(.ADDR_W(4), .FRAME_LEN(16), .SYNC_STAGES(2), .TIMEOUT(B_TMO)) dutB (
    .clk(clk), .reset(reset), .iRQ(rqB), .iVal(valB), .oAddr(addrB), .oBank(bankB),
    .oWe(weB), .oCount(countB), .oDone(doneB), .oOvf(ovfB), .oTimeout(tmoB));

  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor: every strobe is logged as (bank << 16) | address.
  always @(negedge clk) begin
    if (weA) qA.push_back((int'(bankA) << 16) | int'(addrA));
    if (weB) begin
      qB.push_back((int'(bankB) << 16) | int'(addrB));
      lastWeCycB <= cyc;
    end
    if (tmoB && !prevTmoB) tmoRiseCycB <= cyc;
    prevTmoB <= tmoB;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input int expected);
    nCompared++;
    if (actual !== 32'(expected)) begin
      nMismatch++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkAll(input bit sel, input string name, input int eAddr, input int eBank,
                          input int eCount, input int eDone, input int eOvf, input int eTmo);
    if (sel) begin
      checkOutput({name, " oAddr"}, 32'(addrB), eAddr);
      checkOutput({name, " oBank"}, 32'(bankB), eBank);
      checkOutput({name, " oCount"}, 32'(countB), eCount);
      checkOutput({name, " oDone"}, 32'(doneB), eDone);
      checkOutput({name, " oOvf"}, 32'(ovfB), eOvf);
      checkOutput({name, " oTimeout"}, 32'(tmoB), eTmo);
    end else begin
      checkOutput({name, " oAddr"}, 32'(addrA), eAddr);
      checkOutput({name, " oBank"}, 32'(bankA), eBank);
      checkOutput({name, " oCount"}, 32'(countA), eCount);
      checkOutput({name, " oDone"}, 32'(doneA), eDone);
      checkOutput({name, " oOvf"}, 32'(ovfA), eOvf);
      checkOutput({name, " oTimeout"}, 32'(tmoA), eTmo);
    end
  endtask

  // Writes since the last call must be exactly addresses 0..nExp-1 in bank expBank.
  task automatic checkWrites(input bit sel, input string name, input int expBank, input int nExp);
    int got;
    got = sel ? (qB.size() - rdB) : (qA.size() - rdA);
    checkOutput({name, " write count"}, 32'(got), nExp);
    for (int i = 0; i < nExp && i < got; i++) begin
      int w;
      w = sel ? qB[rdB + i] : qA[rdA + i];
      checkOutput($sformatf("%s write %0d", name, i), 32'(w), (expBank << 16) | i);
    end
    if (sel) rdB = qB.size();
    else rdA = qA.size();
  endtask

  task automatic applyStimulus(input bit sel, input int hi, input int lo);
    @(negedge clk);
    if (sel) valB = 1'b1; else valA = 1'b1;
    repeat (hi - 1) @(negedge clk);
    @(negedge clk);
    if (sel) valB = 1'b0; else valA = 1'b0;
    repeat (lo - 1) @(negedge clk);
  endtask

  task automatic pulseIrq(input bit sel, input int len);
    @(negedge clk);
    if (sel) rqB = 1'b1; else rqA = 1'b1;
    repeat (len) @(negedge clk);
    if (sel) rqB = 1'b0; else rqA = 1'b0;
  endtask

  initial begin
    vecT vecs[6];
    int n;
    int kind;
    int expN;
    string nm;

    vecs[0] = '{5,  2, 2, 5,  5, 0, 0, 0, 5};
    vecs[1] = '{16, 3, 3, 16, 0, 1, 0, 0, 16};
    vecs[2] = '{17, 2, 3, 16, 0, 1, 1, 1, 16};
    vecs[3] = '{3,  4, 2, 3,  3, 0, 0, 0, 3};
    vecs[4] = '{16, 2, 2, 16, 0, 1, 0, 0, 16};
    vecs[5] = '{0,  2, 2, 0,  0, 0, 0, 1, 0};

    repeat (3) @(negedge clk);
    checkAll(0, "reset A", 0, 0, 0, 0, 0, 0);
    checkOutput("reset A oWe", 32'(weA), 0);
    checkAll(1, "reset B", 0, 0, 0, 0, 0, 0);
    checkOutput("reset B oWe", 32'(weB), 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Short frames on the 16-byte instance, including the 15->0 wrap and overflow.
    for (int r = 0; r < 6; r++) begin
      pulseIrq(1, 1);
      for (int p = 0; p < vecs[r].nPulses; p++) applyStimulus(1, vecs[r].hi, vecs[r].lo);
      repeat (6) @(negedge clk);
      nm = $sformatf("vec%0d", r);
      checkWrites(1, nm, vecs[r].expBank, vecs[r].expWrites);
      checkAll(1, nm, vecs[r].expAddr, vecs[r].expBank, vecs[r].expCount,
               vecs[r].expDone, vecs[r].expOvf, 0);
    end

    // Synchroniser latency: first sampled at edge k, count visible after edge k+2.
    pulseIrq(1, 1);
    @(negedge clk) valB = 1'b1;
    @(negedge clk);
    @(negedge clk) checkOutput("latency after k+1", 32'(countB), 0);
    @(negedge clk) checkOutput("latency after k+2", 32'(countB), 1);
    valB = 1'b0;
    repeat (6) @(negedge clk);
    checkWrites(1, "latency", 1, 1);

    // Inter-byte timeout after 10 bytes, then edges must be ignored in the error state.
    pulseIrq(1, 1);
    for (int p = 0; p < 10; p++) applyStimulus(1, 2, 2);
    repeat (40) @(negedge clk);
    checkOutput("timeout gap", 32'(tmoRiseCycB - lastWeCycB), B_TMO);
    checkWrites(1, "timeout", 1, 10);
    checkAll(1, "timeout", 10, 1, 10, 0, 0, 1);
    for (int p = 0; p < 2; p++) applyStimulus(1, 2, 2);
    repeat (6) @(negedge clk);
    checkWrites(1, "err ignore", 1, 0);
    checkAll(1, "err ignore", 10, 1, 10, 0, 0, 1);

    // Full 144-byte frame into bank 0.
    pulseIrq(0, 1);
    repeat (A_LEN) applyStimulus(0, 3, 3);
    repeat (6) @(negedge clk);
    checkWrites(0, "frame1", 0, A_LEN);
    checkAll(0, "frame1", 144, 0, 144, 1, 0, 0);

    // Restart after a completed frame flips the bank; reset mid-frame clears everything.
    pulseIrq(0, 1);
    checkAll(0, "restart", 0, 1, 0, 0, 0, 0);
    repeat (60) applyStimulus(0, 2, 2);
    repeat (6) @(negedge clk);
    checkWrites(0, "bank1 partial", 1, 60);
    checkOutput("bank1 partial oCount", 32'(countA), 60);
    @(negedge clk) valA = 1'b1;
    @(negedge clk) reset = 1'b0;
    #1;
    checkAll(0, "mid reset", 0, 0, 0, 0, 0, 0);
    checkOutput("mid reset oWe", 32'(weA), 0);
    @(negedge clk);
    reset = 1'b1;
    valA = 1'b0;
    repeat (4) @(negedge clk);
    bankM = 0;
    prevDoneM = 0;

    // 145 pulses: last one lands in DONE and only raises the overflow flag.
    pulseIrq(0, 1);
    repeat (A_LEN + 1) applyStimulus(0, 3, 3);
    repeat (6) @(negedge clk);
    checkWrites(0, "overflow", 0, A_LEN);
    checkAll(0, "overflow", 144, 0, 144, 1, 1, 0);
    applyStimulus(0, 2, 2);
    repeat (6) @(negedge clk);
    checkWrites(0, "overflow hold", 0, 0);
    checkAll(0, "overflow hold", 144, 0, 144, 1, 1, 0);
    prevDoneM = 1;

    // Randomized frames scored against a frame-level model.
    for (int f = 0; f < 4; f++) begin
      kind = int'($urandom_range(0, 2));
      if (kind == 0) n = int'($urandom_range(1, 143));
      else if (kind == 1) n = A_LEN;
      else n = int'($urandom_range(145, 147));
      if (prevDoneM != 0) bankM = bankM ^ 1;
      pulseIrq(0, int'($urandom_range(1, 3)));
      for (int p = 0; p < n; p++)
        applyStimulus(0, int'($urandom_range(2, 5)), int'($urandom_range(2, 5)));
      repeat (6) @(negedge clk);
      expN = (n < A_LEN) ? n : A_LEN;
      nm = $sformatf("rand%0d n=%0d", f, n);
      checkWrites(0, nm, bankM, expN);
      checkAll(0, nm, expN % 256, bankM, expN, (n >= A_LEN) ? 1 : 0, (n > A_LEN) ? 1 : 0, 0);
      prevDoneM = (n >= A_LEN) ? 1 : 0;
    end

    // iRQ in the same cycle as the detected fall of byte 50 drops that write.
    if (prevDoneM != 0) bankM = bankM ^ 1;
    pulseIrq(0, 1);
    repeat (49) applyStimulus(0, 3, 3);
    repeat (6) @(negedge clk);
    checkWrites(0, "pre coincide", bankM, 49);
    @(negedge clk) valA = 1'b1;
    repeat (2) @(negedge clk);
    @(negedge clk) valA = 1'b0;
    @(negedge clk);
    @(negedge clk) rqA = 1'b1;
    @(negedge clk) rqA = 1'b0;
    repeat (6) @(negedge clk);
    checkWrites(0, "coincide", bankM, 0);
    checkAll(0, "coincide", 0, bankM, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
